// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit hex display driver.
// Double-buffered loads, blanking, leading-zero suppression.
module seven_segment_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dpIn,
  input  logic [DIGITS-1:0]     blankIn,
  input  logic                  lzsEn,
  output logic                  busy,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     anodes
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SegInv = (SEG_ACT_LOW != 0);
  localparam logic AnInv  = (AN_ACT_LOW != 0);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         digitIdx;
  logic [4*DIGITS-1:0]   pendValue;
  logic [DIGITS-1:0]     pendDp;
  logic [DIGITS-1:0]     pendBlank;
  logic [4*DIGITS-1:0]   dispValue;
  logic [DIGITS-1:0]     dispDp;
  logic [DIGITS-1:0]     dispBlank;

  logic                  slotWrap;
  logic                  lastDigit;
  logic                  frameEnd;
  logic [3:0]            nibble;
  logic                  curDp;
  logic                  curBlank;
  logic                  nonZeroAbove;
  logic                  dark;
  logic [6:0]            segHi;
  logic [6:0]            segNext;
  logic                  dpNext;
  logic [DIGITS-1:0]     anNext;

  assign slotWrap  = (prescaler == PW'(PRESCALE - 1));
  assign lastDigit = (digitIdx == IW'(DIGITS - 1));
  assign frameEnd  = slotWrap && lastDigit;

  // Scan timing: prescaler per slot, digit index per frame.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      prescaler <= '0;
      digitIdx  <= '0;
    end else if (slotWrap) begin
      prescaler <= '0;
      digitIdx  <= lastDigit ? '0 : digitIdx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Pending buffer capture and frame-boundary swap into display.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pendValue <= '0;
      pendDp    <= '0;
      pendBlank <= '0;
      dispValue <= '0;
      dispDp    <= '0;
      dispBlank <= '0;
      busy      <= 1'b0;
    end else begin
      if (frameEnd && busy) begin
        dispValue <= pendValue;
        dispDp    <= pendDp;
        dispBlank <= pendBlank;
      end
      if (load) begin
        pendValue <= value;
        pendDp    <= dpIn;
        pendBlank <= blankIn;
      end
      busy <= load || (busy && !frameEnd);
    end
  end

  // Select the current digit and work out whether it is dark.
  always_comb begin
    nibble       = '0;
    curDp        = 1'b0;
    curBlank     = 1'b0;
    nonZeroAbove = 1'b0;
    anNext       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digitIdx == IW'(i)) begin
        nibble   = dispValue[4*i +: 4];
        curDp    = dispDp[i];
        curBlank = dispBlank[i];
        anNext[i] = (prescaler >= PW'(BLANK_CYCLES));
      end
      if (IW'(i) >= digitIdx && dispValue[4*i +: 4] != 4'h0)
        nonZeroAbove = 1'b1;
    end
    dark = curBlank ||
           (lzsEn && digitIdx != '0 && !nonZeroAbove);
  end

  // Hex to active-high gfedcba.
  always_comb begin
    segHi = 7'h00;
    unique case (nibble)
      4'h0: segHi = 7'h3F;
      4'h1: segHi = 7'h06;
      4'h2: segHi = 7'h5B;
      4'h3: segHi = 7'h4F;
      4'h4: segHi = 7'h66;
      4'h5: segHi = 7'h6D;
      4'h6: segHi = 7'h7D;
      4'h7: segHi = 7'h07;
      4'h8: segHi = 7'h7F;
      4'h9: segHi = 7'h6F;
      4'hA: segHi = 7'h77;
      4'hB: segHi = 7'h7C;
      4'hC: segHi = 7'h39;
      4'hD: segHi = 7'h5E;
      4'hE: segHi = 7'h79;
      4'hF: segHi = 7'h71;
    endcase
    segNext = dark ? 7'h00 : segHi;
    dpNext  = dark ? 1'b0 : curDp;
  end

  // Registered pin drivers with polarity applied.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      segments <= {7{SegInv}};
      dp       <= SegInv;
      anodes   <= {DIGITS{AnInv}};
    end else begin
      segments <= segNext ^ {7{SegInv}};
      dp       <= dpNext ^ SegInv;
      anodes   <= anNext ^ {DIGITS{AnInv}};
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver.
// 4 digits, 4-cycle slots, 1 blank cycle, active-low pins.
module tb_seven_segment_scan_driver;

  logic        clock = 1'b0;
  logic        resetN;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dpIn;
  logic [3:0]  blankIn;
  logic        lzsEn;
  logic        busy;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anodes;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  seven_segment_scan_driver #(
    .DIGITS(4),
    .PRESCALE(4),
    .BLANK_CYCLES(1),
    .SEG_ACT_LOW(1),
    .AN_ACT_LOW(1)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .load(load),
    .value(value),
    .dpIn(dpIn),
    .blankIn(blankIn),
    .lzsEn(lzsEn),
    .busy(busy),
    .segments(segments),
    .dp(dp),
    .anodes(anodes)
  );

  task automatic checkVal(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) tick();
  endtask

  function automatic logic [3:0] anOn(input int d);
    logic [3:0] m;
    m = 4'b0001 << d;
    return ~m;
  endfunction

  logic [3:0] anSeq [8];
  logic [6:0] beef  [4];
  logic [6:0] s5678 [4];

  initial begin
    anSeq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
    beef  = '{7'h0E, 7'h06, 7'h06, 7'h03};
    s5678 = '{7'h00, 7'h78, 7'h02, 7'h12};

    resetN  = 1'b1;
    load    = 1'b0;
    value   = '0;
    dpIn    = '0;
    blankIn = '0;
    lzsEn   = 1'b0;
    #1 resetN = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkVal("rst_an", anodes, 4'hF);
    checkVal("rst_seg", segments, 7'h7F);
    checkVal("rst_dp", dp, 1'b1);
    checkVal("rst_busy", busy, 1'b0);
    resetN = 1'b1;
    cyc = 0;

    for (int i = 0; i < 8; i++) begin
      tick();
      checkVal($sformatf("scan_an%0d", i), anodes, anSeq[i]);
    end
    checkVal("idle_seg", segments, 7'h40);

    value = 16'hBEEF;
    load = 1'b1;
    tick();
    load = 1'b0;
    checkVal("beef_busy", busy, 1'b1);
    stepTo(14);
    checkVal("no_tear", segments, 7'h40);
    stepTo(15);
    checkVal("beef_busy_end", busy, 1'b1);
    stepTo(16);
    checkVal("beef_busy_clr", busy, 1'b0);
    for (int d = 0; d < 4; d++) begin
      stepTo(18 + 4*d);
      checkVal($sformatf("beef_seg%0d", d), segments, beef[d]);
      checkVal($sformatf("beef_an%0d", d), anodes, anOn(d));
    end

    stepTo(33);
    value = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    checkVal("l1_busy", busy, 1'b1);
    stepTo(37);
    value = 16'h5678;
    load = 1'b1;
    tick();
    load = 1'b0;
    stepTo(42);
    checkVal("old_frame", segments, 7'h06);
    stepTo(47);
    checkVal("l2_busy", busy, 1'b1);
    stepTo(48);
    checkVal("l2_clr", busy, 1'b0);
    for (int d = 0; d < 4; d++) begin
      stepTo(50 + 4*d);
      checkVal($sformatf("s5678_%0d", d), segments, s5678[d]);
    end

    value = 16'h0070;
    lzsEn = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    stepTo(66);
    checkVal("lzs_d0", segments, 7'h40);
    checkVal("lzs_an0", anodes, 4'hE);
    stepTo(70);
    checkVal("lzs_d1", segments, 7'h78);
    stepTo(74);
    checkVal("lzs_d2", segments, 7'h7F);
    checkVal("lzs_dp2", dp, 1'b1);
    stepTo(78);
    checkVal("lzs_d3", segments, 7'h7F);
    stepTo(80);
    lzsEn = 1'b0;
    tick();
    blankIn = 4'b0101;
    dpIn = 4'b1000;
    load = 1'b1;
    tick();
    load = 1'b0;
    stepTo(90);
    checkVal("nolzs_d2", segments, 7'h40);
    stepTo(94);
    checkVal("nolzs_d3", segments, 7'h40);

    stepTo(98);
    checkVal("blk_d0", segments, 7'h7F);
    checkVal("blk_dp0", dp, 1'b1);
    stepTo(102);
    checkVal("blk_d1", segments, 7'h78);
    checkVal("blk_dp1", dp, 1'b1);
    stepTo(106);
    checkVal("blk_d2", segments, 7'h7F);
    stepTo(110);
    checkVal("blk_d3", segments, 7'h40);
    checkVal("blk_dp3", dp, 1'b0);
    checkVal("blk_an3", anodes, 4'h7);

    stepTo(112);
    value = 16'hFFFF;
    blankIn = '0;
    dpIn = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    checkVal("pre_rst_busy", busy, 1'b1);
    #2 resetN = 1'b0;
    #1;
    checkVal("mid_rst_busy", busy, 1'b0);
    checkVal("mid_rst_an", anodes, 4'hF);
    checkVal("mid_rst_seg", segments, 7'h7F);
    checkVal("mid_rst_dp", dp, 1'b1);
    #1 resetN = 1'b1;
    cyc = 0;
    stepTo(2);
    checkVal("post_rst_an", anodes, 4'hE);
    checkVal("post_rst_seg", segments, 7'h40);
    checkVal("post_rst_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
